// File: rtl/rca_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rca_seq_ctrl
//
// Purpose:
//   Computes a WIDTH-bit add or subtract using a single shared 4-bit
//   ripple-carry slice. One nibble is processed per clock, from the least
//   significant nibble to the most significant. A registered carry links
//   each slice pass to the next one. The wide carry chain is traded for
//   NSLICE clock cycles of latency.
//
// Parameters:
//   WIDTH  operand/result width in bits. Must be a multiple of 4 and at
//          least 8. NSLICE = WIDTH/4 slice passes are needed per operation.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset. Aborts any operation in flight.
//   start  request pulse. Only honoured while the controller is idle.
//   sub    0 selects a+b+cin. 1 selects a-b (two's complement, cin ignored).
//   cin    carry-in for add mode
//   a, b   operands, captured on an accepted start
//   busy   high while slices are being processed
//   done   one-cycle completion pulse
//   sum    result register. Holds partial results while busy.
//   cout   final carry-out (add: carry; subtract: 1 means no borrow)
//   ovf    signed overflow of the final result
// ---------------------------------------------------------------------------
module rca_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic [IDXW-1:0]  idx;
   logic             carry;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       slice_sum;
   logic [4:0]       ripple;
   logic             last_slice;

   // The state register. Reset returns the controller to IDLE no matter
   // what it was doing, so a half-finished operation is simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A start request is only looked at in IDLE. Starts
   // seen in RUN or DONE fall through without effect, and nothing queues
   // them. DONE always lasts a single cycle, which produces the one-cycle
   // done pulse.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (last_slice) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Select the nibble of each latched operand that the shared slice works
   // on in this cycle. The index is scaled by four through concatenation.
   // This keeps the select index exactly as wide as the operand address.
   always_comb begin
      nib_a      = op_a[{idx, 2'b00} +: 4];
      nib_b      = op_b[{idx, 2'b00} +: 4];
      last_slice = (idx == LAST_IDX);
   end

   // The shared 4-bit ripple-carry slice. It is built from four explicit
   // full adders, so the carry chain really is only four cells long. The
   // registered carry from the previous pass enters at ripple[0].
   always_comb begin
      ripple    = '0;
      slice_sum = '0;
      ripple[0] = carry;
      for (int i = 0; i < 4; i++) begin
         slice_sum[i] = nib_a[i] ^ nib_b[i] ^ ripple[i];
         ripple[i+1] = (nib_a[i] & nib_b[i]) |
                       (nib_a[i] & ripple[i]) |
                       (nib_b[i] & ripple[i]);
      end
   end

   // Datapath registers.
   // On an accepted start the operands are captured. For subtraction, B is
   // inverted and the carry is preset to 1, so the slice only ever adds.
   // Each RUN cycle writes one nibble of the result and passes the slice
   // carry on to the next nibble. The last pass also records the final
   // carry. It records signed overflow as well: both addends share a sign
   // bit, but the new result's sign bit differs from it. The result
   // registers are not touched in IDLE or DONE. The previous answer
   // therefore stays visible until the next operation starts overwriting
   // it.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx   <= '0;
         carry <= 1'b0;
         op_a  <= '0;
         op_b  <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               sum[{idx, 2'b00} +: 4] <= slice_sum;
               carry                  <= ripple[4];
               if (last_slice) begin
                  idx  <= '0;
                  cout <= ripple[4];
                  ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                          (slice_sum[3] != op_a[WIDTH-1]);
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status outputs are decoded straight from the state register. They
   // therefore have no combinational path from any input.
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rca_seq_ctrl
//
// Self-checking bench for rca_seq_ctrl. Every accepted operation pushes its
// expected sum/cout/ovf, computed with plain integer arithmetic, into a
// queue. A monitor process pops and compares on every done pulse. Directed
// cases cover carry ripple, overflow, ignored starts and mid-run reset.
// Random operations follow the directed cases.
// ---------------------------------------------------------------------------
module tb_rca_seq_ctrl;

   localparam int WIDTH  = 16;
   localparam int NSLICE = WIDTH / 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   exp_t expq[$];
   int   checks     = 0;
   int   errors     = 0;
   int   doneCount  = 0;
   int   pushCount  = 0;

   rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .cin   (cin),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model written in integer arithmetic. The operands are
   // treated both as unsigned numbers (for the result and carry) and as
   // signed numbers (for overflow: the true result leaves the signed range).
   function automatic exp_t refModel(input logic [WIDTH-1:0] ia,
                                     input logic [WIDTH-1:0] ib,
                                     input logic isub,
                                     input logic icin);
      exp_t   r;
      longint ua, ub, sa, sb, tot, sres, smax, smin;
      ua   = longint'(ia);
      ub   = longint'(ib);
      sa   = longint'($signed(ia));
      sb   = longint'($signed(ib));
      smax = (longint'(1) <<< (WIDTH - 1)) - 1;
      smin = -(longint'(1) <<< (WIDTH - 1));
      if (isub) begin
         tot    = ua - ub;
         r.cout = (ua >= ub);
         sres   = sa - sb;
      end else begin
         tot    = ua + ub + longint'(icin);
         r.cout = (tot >= (longint'(1) <<< WIDTH));
         sres   = sa + sb + longint'(icin);
      end
      r.sum = tot[WIDTH-1:0];
      r.ovf = (sres > smax) || (sres < smin);
      return r;
   endfunction

   // One comparison. It logs a FAIL line with actual and expected values.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Records a timeout as a failed comparison, so the run still ends.
   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   // Monitor: each done pulse retires exactly one queued expectation. A
   // done that arrives with nothing queued is itself an error. The monitor
   // also checks that done never stays high for two consecutive cycles.
   initial begin
      logic prevDone;
      exp_t e;
      prevDone = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && done === 1'b1) begin
            doneCount++;
            checkOutput("done_pulse_prev", 64'(prevDone), 64'(0));
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: got done with empty queue, expected none");
            end else begin
               e = expq.pop_front();
               checkOutput("sum",  64'(sum),  64'(e.sum));
               checkOutput("cout", 64'(cout), 64'(e.cout));
               checkOutput("ovf",  64'(ovf),  64'(e.ovf));
            end
         end
         prevDone = (!rst && done === 1'b1);
      end
   end

   // Waits for an idle cycle and launches one operation. It then scrambles
   // the inputs, which must not affect the captured operands, and checks
   // the busy length and the done latency.
   task automatic applyStimulus(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                input logic isub, input logic icin);
      bit ok;
      int lat;
      int busyCnt;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy === 1'b0 && done === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         timeoutFail("idle_wait");
         return;
      end
      a     = ia;
      b     = ib;
      sub   = isub;
      cin   = icin;
      start = 1'b1;
      expq.push_back(refModel(ia, ib, isub, icin));
      pushCount++;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      lat     = 0;
      busyCnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy === 1'b1) busyCnt++;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      checkOutput("latency", 64'(lat), 64'(NSLICE + 1));
      checkOutput("busy_cycles", 64'(busyCnt), 64'(NSLICE));
   endtask

   function automatic logic [WIDTH-1:0] pickOperand();
      logic [WIDTH-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(WIDTH-1){1'b0}}};
         3:       v = {1'b0, {(WIDTH-1){1'b1}}};
         default: v = WIDTH'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      int cnt;
      bit seen;
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      cin   = 1'b0;
      a     = '0;
      b     = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_done", 64'(done), 64'(0));
      checkOutput("reset_sum",  64'(sum),  64'(0));
      checkOutput("reset_cout", 64'(cout), 64'(0));
      checkOutput("reset_ovf",  64'(ovf),  64'(0));

      // Directed arithmetic cases
      applyStimulus(WIDTH'(16'h1234), WIDTH'(16'h4321), 1'b0, 1'b0);
      applyStimulus('1,               WIDTH'(1),        1'b0, 1'b0);
      applyStimulus({1'b0, {(WIDTH-1){1'b1}}}, WIDTH'(1), 1'b0, 1'b0);
      applyStimulus('0,               '0,               1'b0, 1'b1);
      applyStimulus(WIDTH'(5),        WIDTH'(7),        1'b1, 1'b1);
      applyStimulus({1'b1, {(WIDTH-1){1'b0}}}, WIDTH'(1), 1'b1, 1'b0);

      // start held high through RUN and DONE, with operands changed after
      // acceptance. The first result must use the captured operands. The
      // second operation may only begin from the IDLE cycle after DONE.
      @(negedge clk);
      a     = WIDTH'(16'h1111);
      b     = WIDTH'(16'h1111);
      sub   = 1'b0;
      cin   = 1'b0;
      start = 1'b1;
      expq.push_back(refModel(WIDTH'(16'h1111), WIDTH'(16'h1111), 1'b0, 1'b0));
      expq.push_back(refModel('1, WIDTH'(16'h0F0F), 1'b1, 1'b1));
      pushCount += 2;
      @(posedge clk);
      #1;
      a   = '1;
      b   = WIDTH'(16'h0F0F);
      sub = 1'b1;
      cin = 1'b1;
      cnt  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cnt  = i;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) timeoutFail("held_start_done");
      checkOutput("held_start_latency", 64'(cnt), 64'(NSLICE + 1));
      @(negedge clk);
      checkOutput("restart_gap_busy", 64'(busy), 64'(0));
      checkOutput("restart_gap_done", 64'(done), 64'(0));
      @(negedge clk);
      checkOutput("restart_from_idle", 64'(busy), 64'(1));
      start = 1'b0;
      cnt  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cnt  = i;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) timeoutFail("restart_done");
      checkOutput("restart_latency", 64'(cnt), 64'(NSLICE));

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      a     = WIDTH'(16'h1234);
      b     = WIDTH'(16'h4321);
      sub   = 1'b0;
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrun_reset_busy", 64'(busy), 64'(0));
      checkOutput("midrun_reset_done", 64'(done), 64'(0));
      checkOutput("midrun_reset_sum",  64'(sum),  64'(0));
      checkOutput("midrun_reset_cout", 64'(cout), 64'(0));
      checkOutput("midrun_reset_ovf",  64'(ovf),  64'(0));
      applyStimulus(WIDTH'(16'h00FF), WIDTH'(1), 1'b0, 1'b0);

      // Randomised regression
      for (int n = 0; n < 1000; n++) begin
         applyStimulus(pickOperand(), pickOperand(), 1'($urandom), 1'($urandom));
      end

      repeat (5) @(negedge clk);
      checkOutput("queue_empty", 64'(expq.size()), 64'(0));
      checkOutput("done_count",  64'(doneCount),   64'(pushCount));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
